writeback_port_arbiter: RTL and testbench
=========================================

Name: writeback_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency multi-cycle unit (mul/div) result stream. Pipeline writebacks always win and pass through with zero latency. Multi-cycle results are buffered in a small FIFO and retired in cycles where the pipeline does not write. The block exposes pending-destination lookups for decode hazard checks, and raises a stall request when a buffered result is starved.

Parameters:
DEPTH, 2, result FIFO entries; power of two, >= 2
STARVE_LIMIT, 4, consecutive blocked cycles of the FIFO head before o_StallRequest asserts; >= 1

Ports:
i_Clock  in  1  system clock, rising edge
i_Reset_n  in  1  asynchronous active-low reset
i_PipeWriteback  in  WritebackSignals_t  pipeline writeback request (RegWrite, rd, Value)
i_McValid  in  1  multi-cycle result valid
o_McReady  out  1  FIFO can accept a result this cycle
i_McRd  in  RegisterID_t  multi-cycle destination register
i_McValue  in  32  multi-cycle result value
o_RegFileWrite  out  WritebackSignals_t  register-file write port (RegWrite, rd, Value)
o_StallRequest  out  1  to hazard unit: insert one bubble so the FIFO head can retire
i_QueryRs1  in  RegisterID_t  decode source 1
i_QueryRs2  in  RegisterID_t  decode source 2
o_Rs1Pending  out  1  i_QueryRs1 matches a buffered destination
o_Rs2Pending  out  1  i_QueryRs2 matches a buffered destination
o_Occupancy  out  $clog2(DEPTH+1)  valid FIFO entries

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; read/write pointers = 0; starve counter = 0.
  - o_StallRequest = 0; o_Occupancy = 0; o_McReady = 1.
  - o_RegFileWrite.RegWrite = 0 and o_Rs*Pending = 0 while reset is asserted.
  - Reset mid-operation drops all buffered results without writing them.
- Pipeline path (combinational, 0 latency):
  - PipeWins = i_PipeWriteback.RegWrite && rd != 0.
  - If PipeWins, o_RegFileWrite = i_PipeWriteback.
  - A pipeline write with rd == 0 is suppressed (RegWrite = 0) and does not block the FIFO.
- FIFO path:
  - o_McReady = (occupancy < DEPTH). Handshake fires on i_McValid && o_McReady.
  - An accepted result with i_McRd == 0 is discarded and not enqueued.
  - Minimum latency from accept to port write is 1 cycle; no same-cycle bypass.
  - Pop when the FIFO is non-empty and !PipeWins. In that cycle o_RegFileWrite = {1, head rd, head value}.
  - Push and pop in the same cycle: both happen, occupancy unchanged. When full, o_McReady = 0 even if a pop occurs that cycle (no combinational ready-from-pop path).
  - Pointers wrap modulo DEPTH. Occupancy is tracked in a separate counter.
- No write: o_RegFileWrite.RegWrite = 0; rd and Value are don't-care (drive 0).
- Starve counter:
  - Increments each cycle the FIFO is non-empty and PipeWins; saturates at STARVE_LIMIT.
  - Clears on pop and when the FIFO is empty.
  - o_StallRequest = (counter == STARVE_LIMIT), registered. It stays high until the pop that the bubble enables, then deasserts the next cycle.
- Pending lookup (combinational): o_RsNPending = 1 if any valid entry has rd == i_QueryRsN and i_QueryRsN != 0. An entry popping this cycle still counts as pending.
- Ordering precondition (checked by assertion, not handled): decode never issues a pipeline write to an rd that is pending in the FIFO or outstanding in the multi-cycle unit.

Decomposition:
- Shared package: WritebackSignals_t and RegisterID_t (existing), plus a new McResult_t {rd, Value} struct used for the FIFO entry.
- One sub-module is natural: sync_fifo (parameterised width/depth; push, pop, full, empty, count, plus a per-entry valid/rd view for the pending compare).
- Arbitration, starve counter and lookup stay in the top module.

Test Plan:
- Idle pipeline, McValid with rd=5, value=0xDEADBEEF, at cycle 0 -> accept at 0; port writes x5=0xDEADBEEF at cycle 1; occupancy 1 then 0.
- Pipeline writes x3=1 every cycle; McValid x7 at cycle 0; STARVE_LIMIT=4 -> no x7 write; StallRequest high at cycle 5; drop pipeline write at cycle 6 -> x7 written at 6; StallRequest low at 7.
- Fill FIFO: two Mc results (x8, x9) under continuous pipeline writes -> o_McReady=0, third result held; first free cycle writes x8, next writes x9, in order.
- Mc result with rd=0 -> accepted, never written, occupancy stays 0. Pipeline RegWrite=1 with rd=0 while FIFO holds x4 -> x4 retires that cycle.
- Query x9 while x9 is buffered -> o_Rs1Pending=1, o_Rs2Pending=0 for x10. Query x0 -> 0 even with an x0 lookup.
- Reset_n low mid-stream with 2 buffered entries -> outputs low immediately; after release occupancy 0, McReady 1, no stale writes.

Source files
------------

// File: rtl/writeback_port_arbiter_pkg.sv
// Shared types for the register-file writeback port arbiter.
package writeback_port_arbiter_pkg;

   typedef logic [4:0] RegisterID_t;

   typedef struct packed {
      logic        RegWrite;
      RegisterID_t rd;
      logic [31:0] Value;
   } WritebackSignals_t;

   // rd sits in the MSBs so the FIFO can expose it as a tag without knowing the layout
   typedef struct packed {
      RegisterID_t rd;
      logic [31:0] Value;
   } McResult_t;

   localparam RegisterID_t REG_ZERO = '0;

endpackage

// File: rtl/writeback_port_arbiter_if.sv
// Pipeline/multi-cycle writeback, register-file port and decode lookup bundle.
interface writeback_port_arbiter_if #(
   parameter int unsigned DEPTH = 2
);
   import writeback_port_arbiter_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   WritebackSignals_t i_PipeWriteback;
   logic              i_McValid;
   logic              o_McReady;
   RegisterID_t       i_McRd;
   logic [31:0]       i_McValue;
   WritebackSignals_t o_RegFileWrite;
   logic              o_StallRequest;
   RegisterID_t       i_QueryRs1;
   RegisterID_t       i_QueryRs2;
   logic              o_Rs1Pending;
   logic              o_Rs2Pending;
   logic [CNT_W-1:0]  o_Occupancy;

   modport slave (
      input  i_PipeWriteback, i_McValid, i_McRd, i_McValue, i_QueryRs1, i_QueryRs2,
      output o_McReady, o_RegFileWrite, o_StallRequest, o_Rs1Pending, o_Rs2Pending, o_Occupancy
   );

   modport master (
      output i_PipeWriteback, i_McValid, i_McRd, i_McValue, i_QueryRs1, i_QueryRs2,
      input  o_McReady, o_RegFileWrite, o_StallRequest, o_Rs1Pending, o_Rs2Pending, o_Occupancy
   );

endinterface

// File: rtl/writeback_port_arbiter_sync_fifo.sv
// Small synchronous FIFO with an occupancy counter and a per-entry valid/tag view.
module writeback_port_arbiter_sync_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 5,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic                         full,
   output logic                         empty,
   output logic [CNT_W-1:0]             count,
   output logic [DEPTH-1:0]             entry_valid,
   output logic [DEPTH-1:0][TAG_W-1:0]  entry_tag
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic                        push_ok, pop_ok;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q]   = push_data;
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      entry_valid = valid_q;
      entry_tag   = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         entry_tag[i] = mem_q[i][WIDTH-1 -: TAG_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/writeback_port_arbiter.sv
// Shares the register-file write port: pipeline writebacks pass straight through,
// multi-cycle results queue and retire in free cycles, with a starvation stall request.
module writeback_port_arbiter
   import writeback_port_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset_n,
   writeback_port_arbiter_if.slave   bus
);
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned RES_W    = $bits(McResult_t);
   localparam int unsigned TAG_W    = $bits(RegisterID_t);

   logic                          pipe_wins, mc_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0]              fifo_count;
   logic [DEPTH-1:0]              entry_valid;
   logic [DEPTH-1:0][TAG_W-1:0]   entry_tag;
   McResult_t                     mc_in, head;
   logic [STARVE_W-1:0]           starve_left_q, starve_left_d;
   logic                          rs1_hit, rs2_hit, pipe_rd_hit;

   assign pipe_wins = i_Reset_n && bus.i_PipeWriteback.RegWrite
                      && (bus.i_PipeWriteback.rd != REG_ZERO);
   // x0 results complete the handshake but are never queued
   assign mc_push   = bus.i_McValid && !fifo_full && (bus.i_McRd != REG_ZERO);
   assign fifo_pop  = !fifo_empty && !pipe_wins;
   assign mc_in     = '{rd: bus.i_McRd, Value: bus.i_McValue};

   writeback_port_arbiter_sync_fifo #(
      .WIDTH (RES_W),
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_fifo (
      .clk         (i_Clock),
      .rst_n       (i_Reset_n),
      .push        (mc_push),
      .push_data   (mc_in),
      .pop         (fifo_pop),
      .head_data   (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count),
      .entry_valid (entry_valid),
      .entry_tag   (entry_tag)
   );

   assign bus.o_McReady   = !fifo_full;
   assign bus.o_Occupancy = fifo_count;

   always_comb begin
      bus.o_RegFileWrite = '0;
      if (pipe_wins) begin
         bus.o_RegFileWrite = bus.i_PipeWriteback;
      end else if (fifo_pop) begin
         bus.o_RegFileWrite = '{RegWrite: 1'b1, rd: head.rd, Value: head.Value};
      end
   end

   always_comb begin
      rs1_hit     = 1'b0;
      rs2_hit     = 1'b0;
      pipe_rd_hit = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (entry_valid[i]) begin
            if (entry_tag[i] == bus.i_QueryRs1)         rs1_hit     = 1'b1;
            if (entry_tag[i] == bus.i_QueryRs2)         rs2_hit     = 1'b1;
            if (entry_tag[i] == bus.i_PipeWriteback.rd) pipe_rd_hit = 1'b1;
         end
      end
   end

   assign bus.o_Rs1Pending = i_Reset_n && rs1_hit && (bus.i_QueryRs1 != REG_ZERO);
   assign bus.o_Rs2Pending = i_Reset_n && rs2_hit && (bus.i_QueryRs2 != REG_ZERO);

   // Down-counts blocked head cycles; terminal count of zero means starved
   always_comb begin
      starve_left_d = starve_left_q;
      if (fifo_empty || fifo_pop) begin
         starve_left_d = STARVE_W'(STARVE_LIMIT);
      end else if (starve_left_q != '0) begin
         starve_left_d = starve_left_q - 1'b1;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         starve_left_q <= STARVE_W'(STARVE_LIMIT);
      end else begin
         starve_left_q <= starve_left_d;
      end
   end

   assign bus.o_StallRequest = (starve_left_q == '0);

   a_pipe_rd_not_pending: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
      !(pipe_wins && pipe_rd_hit));

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Directed bench for writeback_port_arbiter with DEPTH=2, STARVE_LIMIT=4.
module tb_writeback_port_arbiter;
   import writeback_port_arbiter_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   writeback_port_arbiter_if #(.DEPTH(DEPTH)) bus();

   writeback_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .i_Clock   (clk),
      .i_Reset_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   function automatic WritebackSignals_t wb(logic we, logic [4:0] r, logic [31:0] v);
      return '{RegWrite: we, rd: r, Value: v};
   endfunction

   task automatic drive_idle();
      bus.i_PipeWriteback = '0;
      bus.i_McValid       = 1'b0;
      bus.i_McRd          = '0;
      bus.i_McValue       = '0;
      bus.i_QueryRs1      = '0;
      bus.i_QueryRs2      = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      bus.i_PipeWriteback = wb(1'b1, 5'd3, 32'h1234);
      bus.i_QueryRs1      = 5'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.o_RegFileWrite.RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite: got %b expected 0", bus.o_RegFileWrite.RegWrite); end
      checks++; if (bus.o_Occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", bus.o_Occupancy); end
      checks++; if (bus.o_McReady !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.o_McReady); end
      checks++; if (bus.o_StallRequest !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", bus.o_StallRequest); end
      checks++; if (bus.o_Rs1Pending !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b expected 0", bus.o_Rs1Pending); end
      @(posedge clk);
      #1;
      drive_idle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_pipe();
      WritebackSignals_t vin [4];
      WritebackSignals_t vexp [4];
      vin[0] = wb(1'b1, 5'd3,  32'h0000_0001); vexp[0] = wb(1'b1, 5'd3,  32'h0000_0001);
      vin[1] = wb(1'b1, 5'd31, 32'hFFFF_FFFF); vexp[1] = wb(1'b1, 5'd31, 32'hFFFF_FFFF);
      vin[2] = wb(1'b0, 5'd5,  32'h0000_00AB); vexp[2] = '0;
      vin[3] = wb(1'b1, 5'd0,  32'h0000_0055); vexp[3] = '0;
      for (int k = 0; k < 4; k++) begin
         bus.i_PipeWriteback = vin[k];
         @(negedge clk);
         checks++; if (bus.o_RegFileWrite !== vexp[k]) begin failures++; $display("FAIL pipe_vec%0d: got %h expected %h", k, bus.o_RegFileWrite, vexp[k]); end
         next_cycle();
      end
      drive_idle();
   endtask

   task automatic test_single();
      bus.i_McValid = 1'b1; bus.i_McRd = 5'd5; bus.i_McValue = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (bus.o_McReady !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", bus.o_McReady); end
      checks++; if (bus.o_RegFileWrite.RegWrite !== 1'b0) begin failures++; $display("FAIL single_no_bypass: got %b expected 0", bus.o_RegFileWrite.RegWrite); end
      next_cycle();
      drive_idle();
      @(negedge clk);
      checks++; if (bus.o_RegFileWrite !== wb(1'b1, 5'd5, 32'hDEAD_BEEF)) begin failures++; $display("FAIL single_write: got %h expected %h", bus.o_RegFileWrite, wb(1'b1, 5'd5, 32'hDEAD_BEEF)); end
      checks++; if (bus.o_Occupancy !== 2'd1) begin failures++; $display("FAIL single_occ1: got %0d expected 1", bus.o_Occupancy); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.o_Occupancy !== 2'd0) begin failures++; $display("FAIL single_occ0: got %0d expected 0", bus.o_Occupancy); end
      checks++; if (bus.o_RegFileWrite.RegWrite !== 1'b0) begin failures++; $display("FAIL single_idle: got %b expected 0", bus.o_RegFileWrite.RegWrite); end
      next_cycle();
   endtask

   task automatic test_starve();
      bus.i_PipeWriteback = wb(1'b1, 5'd3, 32'd1);
      bus.i_McValid = 1'b1; bus.i_McRd = 5'd7; bus.i_McValue = 32'h77;
      @(negedge clk);
      checks++; if (bus.o_RegFileWrite !== wb(1'b1, 5'd3, 32'd1)) begin failures++; $display("FAIL starve_c0_write: got %h expected %h", bus.o_RegFileWrite, wb(1'b1, 5'd3, 32'd1)); end
      next_cycle();
      bus.i_McValid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++; if (bus.o_StallRequest !== (c == 5)) begin failures++; $display("FAIL starve_stall_c%0d: got %b expected %b", c, bus.o_StallRequest, (c == 5)); end
         checks++; if (bus.o_RegFileWrite.rd !== 5'd3) begin failures++; $display("FAIL starve_blocked_c%0d: got rd %0d expected 3", c, bus.o_RegFileWrite.rd); end
         next_cycle();
      end
      bus.i_PipeWriteback = '0;
      @(negedge clk);
      checks++; if (bus.o_RegFileWrite !== wb(1'b1, 5'd7, 32'h77)) begin failures++; $display("FAIL starve_retire: got %h expected %h", bus.o_RegFileWrite, wb(1'b1, 5'd7, 32'h77)); end
      checks++; if (bus.o_StallRequest !== 1'b1) begin failures++; $display("FAIL starve_stall_c6: got %b expected 1", bus.o_StallRequest); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.o_StallRequest !== 1'b0) begin failures++; $display("FAIL starve_stall_c7: got %b expected 0", bus.o_StallRequest); end
      checks++; if (bus.o_Occupancy !== 2'd0) begin failures++; $display("FAIL starve_occ_c7: got %0d expected 0", bus.o_Occupancy); end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_full();
      logic              exp_ready [8];
      logic [1:0]        exp_occ   [8];
      WritebackSignals_t exp_wr    [8];
      exp_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_occ   = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
      for (int c = 0; c < 4; c++) exp_wr[c] = wb(1'b1, 5'd3, 32'd2);
      exp_wr[4] = wb(1'b1, 5'd8,  32'h80);
      exp_wr[5] = wb(1'b1, 5'd9,  32'h90);
      exp_wr[6] = wb(1'b1, 5'd10, 32'hA0);
      exp_wr[7] = '0;
      for (int c = 0; c < 8; c++) begin
         bus.i_PipeWriteback = (c < 4) ? wb(1'b1, 5'd3, 32'd2) : '0;
         bus.i_McValid  = (c <= 5);
         bus.i_McRd     = (c == 0) ? 5'd8 : (c == 1) ? 5'd9 : 5'd10;
         bus.i_McValue  = (c == 0) ? 32'h80 : (c == 1) ? 32'h90 : 32'hA0;
         bus.i_QueryRs1 = (c == 4) ? 5'd8 : 5'd9;
         bus.i_QueryRs2 = 5'd10;
         @(negedge clk);
         checks++; if (bus.o_McReady !== exp_ready[c]) begin failures++; $display("FAIL full_ready_c%0d: got %b expected %b", c, bus.o_McReady, exp_ready[c]); end
         checks++; if (bus.o_Occupancy !== exp_occ[c]) begin failures++; $display("FAIL full_occ_c%0d: got %0d expected %0d", c, bus.o_Occupancy, exp_occ[c]); end
         checks++; if (bus.o_RegFileWrite !== exp_wr[c]) begin failures++; $display("FAIL full_write_c%0d: got %h expected %h", c, bus.o_RegFileWrite, exp_wr[c]); end
         if (c == 2) begin
            checks++; if (bus.o_Rs1Pending !== 1'b1) begin failures++; $display("FAIL full_pend_x9: got %b expected 1", bus.o_Rs1Pending); end
            checks++; if (bus.o_Rs2Pending !== 1'b0) begin failures++; $display("FAIL full_pend_x10: got %b expected 0", bus.o_Rs2Pending); end
         end
         if (c == 4) begin
            checks++; if (bus.o_Rs1Pending !== 1'b1) begin failures++; $display("FAIL full_pend_popping_x8: got %b expected 1", bus.o_Rs1Pending); end
            checks++; if (bus.o_StallRequest !== 1'b0) begin failures++; $display("FAIL full_stall_c4: got %b expected 0", bus.o_StallRequest); end
         end
         next_cycle();
      end
      drive_idle();
   endtask

   task automatic test_rd0();
      bus.i_McValid = 1'b1; bus.i_McRd = 5'd0; bus.i_McValue = 32'h1;
      @(negedge clk);
      checks++; if (bus.o_McReady !== 1'b1) begin failures++; $display("FAIL rd0_ready: got %b expected 1", bus.o_McReady); end
      next_cycle();
      drive_idle();
      @(negedge clk);
      checks++; if (bus.o_Occupancy !== 2'd0) begin failures++; $display("FAIL rd0_occ: got %0d expected 0", bus.o_Occupancy); end
      checks++; if (bus.o_RegFileWrite.RegWrite !== 1'b0) begin failures++; $display("FAIL rd0_no_write: got %b expected 0", bus.o_RegFileWrite.RegWrite); end
      next_cycle();
      bus.i_PipeWriteback = wb(1'b1, 5'd3, 32'd2);
      bus.i_McValid = 1'b1; bus.i_McRd = 5'd4; bus.i_McValue = 32'h44;
      next_cycle();
      bus.i_McValid = 1'b0;
      bus.i_PipeWriteback = wb(1'b1, 5'd0, 32'h55);
      @(negedge clk);
      checks++; if (bus.o_RegFileWrite !== wb(1'b1, 5'd4, 32'h44)) begin failures++; $display("FAIL rd0_pipe_x0_retire: got %h expected %h", bus.o_RegFileWrite, wb(1'b1, 5'd4, 32'h44)); end
      next_cycle();
      drive_idle();
      @(negedge clk);
      checks++; if (bus.o_Occupancy !== 2'd0) begin failures++; $display("FAIL rd0_drained: got %0d expected 0", bus.o_Occupancy); end
      next_cycle();
   endtask

   task automatic test_pending();
      bus.i_PipeWriteback = wb(1'b1, 5'd3, 32'd5);
      bus.i_McValid = 1'b1; bus.i_McRd = 5'd9; bus.i_McValue = 32'h99;
      next_cycle();
      bus.i_McValid  = 1'b0;
      bus.i_QueryRs1 = 5'd9; bus.i_QueryRs2 = 5'd10;
      @(negedge clk);
      checks++; if (bus.o_Rs1Pending !== 1'b1) begin failures++; $display("FAIL pend_rs1_x9: got %b expected 1", bus.o_Rs1Pending); end
      checks++; if (bus.o_Rs2Pending !== 1'b0) begin failures++; $display("FAIL pend_rs2_x10: got %b expected 0", bus.o_Rs2Pending); end
      next_cycle();
      bus.i_QueryRs1 = 5'd0; bus.i_QueryRs2 = 5'd9;
      @(negedge clk);
      checks++; if (bus.o_Rs1Pending !== 1'b0) begin failures++; $display("FAIL pend_rs1_x0: got %b expected 0", bus.o_Rs1Pending); end
      checks++; if (bus.o_Rs2Pending !== 1'b1) begin failures++; $display("FAIL pend_rs2_x9: got %b expected 1", bus.o_Rs2Pending); end
      next_cycle();
      bus.i_PipeWriteback = '0;
      bus.i_QueryRs1 = 5'd9;
      @(negedge clk);
      checks++; if (bus.o_RegFileWrite !== wb(1'b1, 5'd9, 32'h99)) begin failures++; $display("FAIL pend_retire_x9: got %h expected %h", bus.o_RegFileWrite, wb(1'b1, 5'd9, 32'h99)); end
      checks++; if (bus.o_Rs1Pending !== 1'b1) begin failures++; $display("FAIL pend_popping: got %b expected 1", bus.o_Rs1Pending); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.o_Rs1Pending !== 1'b0) begin failures++; $display("FAIL pend_after_pop: got %b expected 0", bus.o_Rs1Pending); end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_reset_mid();
      bus.i_PipeWriteback = wb(1'b1, 5'd3, 32'd6);
      bus.i_McValid = 1'b1; bus.i_McRd = 5'd11; bus.i_McValue = 32'hB1;
      next_cycle();
      bus.i_McRd = 5'd12; bus.i_McValue = 32'hC2;
      next_cycle();
      bus.i_McValid  = 1'b0;
      bus.i_QueryRs1 = 5'd11;
      @(negedge clk);
      checks++; if (bus.o_Occupancy !== 2'd2) begin failures++; $display("FAIL rstmid_occ_before: got %0d expected 2", bus.o_Occupancy); end
      checks++; if (bus.o_Rs1Pending !== 1'b1) begin failures++; $display("FAIL rstmid_pend_before: got %b expected 1", bus.o_Rs1Pending); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.o_RegFileWrite.RegWrite !== 1'b0) begin failures++; $display("FAIL rstmid_regwrite: got %b expected 0", bus.o_RegFileWrite.RegWrite); end
      checks++; if (bus.o_Occupancy !== 2'd0) begin failures++; $display("FAIL rstmid_occ: got %0d expected 0", bus.o_Occupancy); end
      checks++; if (bus.o_Rs1Pending !== 1'b0) begin failures++; $display("FAIL rstmid_pend: got %b expected 0", bus.o_Rs1Pending); end
      checks++; if (bus.o_McReady !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b expected 1", bus.o_McReady); end
      @(posedge clk);
      #1;
      drive_idle();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus.o_RegFileWrite.RegWrite !== 1'b0) begin failures++; $display("FAIL rstmid_stale_c%0d: got %h expected no write", c, bus.o_RegFileWrite); end
         checks++; if (bus.o_Occupancy !== 2'd0 || bus.o_McReady !== 1'b1) begin failures++; $display("FAIL rstmid_after_c%0d: got occ %0d ready %b expected occ 0 ready 1", c, bus.o_Occupancy, bus.o_McReady); end
         next_cycle();
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_pipe();
      test_single();
      test_starve();
      test_full();
      test_rd0();
      test_pending();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
